// File: rtl/axon_scheduler_256x256_pkg.sv
// Shared definitions for the axon scheduler: FSM state encoding, weight-type
// typedef, the no-weight select code and default array dimensions.
package axon_scheduler_256x256_pkg;

  localparam int unsigned NUM_AXONS_DFLT   = 256;
  localparam int unsigned NUM_NEURONS_DFLT = 256;

  // Select code for a non-contributing axon; the neuron block maps it to weight 0.
  localparam logic [7:0] WSEL_NONE_DFLT = 8'd4;

  typedef logic [1:0] wtype_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SCAN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/axon_scheduler_256x256_type_table.sv
// axon_type_table: per-axon weight-type register file.
//   clk, rst   : clock, asynchronous active-high reset (clears every entry)
//   wr_en      : write strobe (caller gates it to the idle state)
//   wr_addr    : axon index to write
//   wr_data    : 2-bit weight type
//   rd_addr    : axon index to read (combinational)
//   rd_data    : weight type of rd_addr
module axon_type_table
  import axon_scheduler_256x256_pkg::*;
#(
  parameter int unsigned NUM_AXONS = NUM_AXONS_DFLT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  wtype_t     wr_data,
  input  logic [7:0] rd_addr,
  output wtype_t     rd_data
);

  wtype_t mem_q [NUM_AXONS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_AXONS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axon_scheduler_256x256.sv
// axon_scheduler_256x256: per-time-step sequencer feeding the 256x256 neuron core.
// On start it latches the axon spike vector, then for every neuron row reads the
// crossbar connectivity row and emits one beat per axon carrying the weight-type
// select (or the no-weight code for non-contributing axons).
//   clk, rst                 : clock, asynchronous active-high reset
//   start_i, spike_vec_i     : begin a time step / spike vector latched at start
//   type_wr_en/addr/data_i   : weight-type table write port (idle only)
//   row_rd_o, row_addr_o     : connectivity row read request
//   conn_row_i               : connectivity row, valid one cycle after row_rd_o
//   valid_o, ready_i         : beat handshake
//   neuron_idx_o, axon_idx_o : beat position
//   weight_select_o          : weight type (zero-extended) or WSEL_NONE
//   first_o, last_o          : beat is axon 0 / axon NUM_AXONS-1
//   busy_o, done_o           : not idle / end-of-step pulse
//   active_cnt_o             : contributing-axon count of the last finished neuron
// Build option: define SCHED_ACTIVE_CNT_EN to enable the contributing-axon
// counter; otherwise active_cnt_o is tied to 0.
module axon_scheduler_256x256
  import axon_scheduler_256x256_pkg::*;
#(
  parameter int unsigned NUM_AXONS   = NUM_AXONS_DFLT,
  parameter int unsigned NUM_NEURONS = NUM_NEURONS_DFLT,
  parameter logic [7:0]  WSEL_NONE   = WSEL_NONE_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [NUM_AXONS-1:0] spike_vec_i,
  input  logic                 type_wr_en_i,
  input  logic [7:0]           type_wr_addr_i,
  input  logic [1:0]           type_wr_data_i,
  output logic                 row_rd_o,
  output logic [7:0]           row_addr_o,
  input  logic [NUM_AXONS-1:0] conn_row_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [7:0]           neuron_idx_o,
  output logic [7:0]           axon_idx_o,
  output logic [7:0]           weight_select_o,
  output logic                 first_o,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [8:0]           active_cnt_o
);

  sched_state_t         state_q, state_d;
  logic [NUM_AXONS-1:0] spike_q;
  logic [NUM_AXONS-1:0] conn_q;
  logic [7:0]           neuron_q;
  logic [7:0]           axon_q;
  wtype_t               type_rd;
  logic                 contrib;
  logic                 last_beat;
  logic                 last_neuron;
  logic                 tbl_wr_en;

  assign last_beat   = (axon_q == 8'(NUM_AXONS - 1));
  assign last_neuron = (neuron_q == 8'(NUM_NEURONS - 1));
  assign contrib     = spike_q[axon_q] & conn_q[axon_q];
  // Table is only writable while idle so a step sees one consistent table.
  assign tbl_wr_en   = type_wr_en_i && (state_q == IDLE);

  axon_type_table #(
    .NUM_AXONS(NUM_AXONS)
  ) u_type_table (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (tbl_wr_en),
    .wr_addr(type_wr_addr_i),
    .wr_data(type_wr_data_i),
    .rd_addr(axon_q),
    .rd_data(type_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      spike_q  <= '0;
      conn_q   <= '0;
      neuron_q <= '0;
      axon_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            spike_q  <= spike_vec_i;
            neuron_q <= '0;
          end
        end
        WAIT: begin
          conn_q <= conn_row_i;
          axon_q <= '0;
        end
        SCAN: begin
          if (ready_i) begin
            if (last_beat) begin
              // axon index returns to 0 only when leaving the row; neuron index
              // stays on the final row through DONE.
              axon_q <= '0;
              if (!last_neuron) begin
                neuron_q <= neuron_q + 8'd1;
              end
            end else begin
              axon_q <= axon_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d         = state_q;
    row_rd_o        = 1'b0;
    valid_o         = 1'b0;
    done_o          = 1'b0;
    busy_o          = (state_q != IDLE);
    weight_select_o = '0;
    first_o         = 1'b0;
    last_o          = 1'b0;
    case (state_q)
      IDLE:  if (start_i) state_d = FETCH;
      FETCH: begin
        row_rd_o = 1'b1;
        state_d  = WAIT;
      end
      WAIT:  state_d = SCAN;
      SCAN: begin
        valid_o         = 1'b1;
        weight_select_o = contrib ? {6'b0, type_rd} : WSEL_NONE;
        first_o         = (axon_q == '0);
        last_o          = last_beat;
        if (ready_i && last_beat) begin
          state_d = last_neuron ? DONE : FETCH;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign row_addr_o   = neuron_q;
  assign neuron_idx_o = neuron_q;
  assign axon_idx_o   = axon_q;

`ifdef SCHED_ACTIVE_CNT_EN
  logic [8:0] row_cnt_q;
  logic [8:0] active_cnt_q;
  logic [9:0] row_final;

  // Count including the beat being accepted now, saturated at 256.
  assign row_final = {1'b0, row_cnt_q} + 10'(contrib);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q    <= '0;
      active_cnt_q <= '0;
    end else if (state_q == WAIT) begin
      row_cnt_q <= '0;
    end else if (state_q == SCAN && ready_i) begin
      if (last_beat) begin
        active_cnt_q <= (row_final > 10'd256) ? 9'd256 : row_final[8:0];
      end else begin
        row_cnt_q <= row_final[8:0];
      end
    end
  end

  assign active_cnt_o = active_cnt_q;
`else
  assign active_cnt_o = '0;
`endif

endmodule

// File: tb/tb_axon_scheduler_256x256.sv
`timescale 1ns/1ps
module tb_axon_scheduler_256x256;

  localparam int unsigned NA       = 256;
  localparam int unsigned NN       = 256;
  localparam int unsigned STEP_CYC = NN * (NA + 2) + 1;
`ifdef SCHED_ACTIVE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [NA-1:0] spike_vec_i;
  logic          type_wr_en_i;
  logic [7:0]    type_wr_addr_i;
  logic [1:0]    type_wr_data_i;
  logic          row_rd_o;
  logic [7:0]    row_addr_o;
  logic [NA-1:0] conn_row_i;
  logic          valid_o;
  logic          ready_i;
  logic [7:0]    neuron_idx_o;
  logic [7:0]    axon_idx_o;
  logic [7:0]    weight_select_o;
  logic          first_o;
  logic          last_o;
  logic          busy_o;
  logic          done_o;
  logic [8:0]    active_cnt_o;

  always #5 clk = ~clk;

  axon_scheduler_256x256 dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .spike_vec_i    (spike_vec_i),
    .type_wr_en_i   (type_wr_en_i),
    .type_wr_addr_i (type_wr_addr_i),
    .type_wr_data_i (type_wr_data_i),
    .row_rd_o       (row_rd_o),
    .row_addr_o     (row_addr_o),
    .conn_row_i     (conn_row_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .neuron_idx_o   (neuron_idx_o),
    .axon_idx_o     (axon_idx_o),
    .weight_select_o(weight_select_o),
    .first_o        (first_o),
    .last_o         (last_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .active_cnt_o   (active_cnt_o)
  );

  typedef struct packed {
    logic [7:0] neuron;
    logic [7:0] axon;
    logic [7:0] sel;
    logic       first;
    logic       last;
  } beat_t;

  beat_t         sb[$];
  logic [NA-1:0] spike_m;
  logic [1:0]    type_m [NA];
  int unsigned   fetch_cnt;
  int            conn_mode;
  int            n_checks = 0;
  int            n_pass   = 0;

  // mode 0: every row fully connected. mode 1: row 0 connects axon 5 only;
  // later rows connect axon 7 plus axons 100/101, which never spike.
  function automatic logic [NA-1:0] conn_pattern(input int unsigned row);
    logic [NA-1:0] v;
    v = '0;
    if (conn_mode == 0) v = '1;
    else if (row == 0) v[5] = 1'b1;
    else begin
      v[7]   = 1'b1;
      v[100] = 1'b1;
      v[101] = 1'b1;
    end
    return v;
  endfunction

  // Row responder: answers each row read and queues that row's expected beats.
  always @(negedge clk) begin
    #1;
    if (row_rd_o === 1'b1) begin
      logic [NA-1:0] c;
      n_checks++;
      if (row_addr_o === fetch_cnt[7:0]) n_pass++;
      else $display("FAIL row_addr: got %0d expected %0d", row_addr_o, fetch_cnt[7:0]);
      c = conn_pattern(fetch_cnt);
      conn_row_i = c;
      for (int i = 0; i < int'(NA); i++) begin
        beat_t b;
        b.neuron = fetch_cnt[7:0];
        b.axon   = i[7:0];
        b.sel    = (spike_m[i] && c[i]) ? {6'b0, type_m[i]} : 8'd4;
        b.first  = (i == 0);
        b.last   = (i == int'(NA) - 1);
        sb.push_back(b);
      end
      fetch_cnt++;
    end
  end

  // Beat monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    #1;
    if (valid_o === 1'b1 && ready_i === 1'b1) begin
      beat_t got;
      beat_t exp;
      got = {neuron_idx_o, axon_idx_o, weight_select_o, first_o, last_o};
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL beat_unexpected: got n%0d a%0d sel%0d, expected no beat",
                 got.neuron, got.axon, got.sel);
      end else begin
        exp = sb.pop_front();
        if (got === exp) n_pass++;
        else $display("FAIL beat: got n%0d a%0d sel%0d f%0b l%0b expected n%0d a%0d sel%0d f%0b l%0b",
                      got.neuron, got.axon, got.sel, got.first, got.last,
                      exp.neuron, exp.axon, exp.sel, exp.first, exp.last);
      end
    end
  end

  task automatic write_type(input logic [7:0] a, input logic [1:0] d);
    @(negedge clk);
    type_wr_en_i = 1'b1; type_wr_addr_i = a; type_wr_data_i = d;
    type_m[a] = d;
    @(negedge clk);
    type_wr_en_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b0; spike_vec_i = '0; conn_row_i = '0; ready_i = 1'b1;
    type_wr_en_i = 1'b0; type_wr_addr_i = '0; type_wr_data_i = '0;
    spike_m = '0; fetch_cnt = 0; conn_mode = 0;
    for (int i = 0; i < int'(NA); i++) type_m[i] = 2'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({row_rd_o, row_addr_o, valid_o, neuron_idx_o, axon_idx_o, weight_select_o,
         first_o, last_o, busy_o, done_o, active_cnt_o} === '0) n_pass++;
    else $display("FAIL reset_outputs: got busy=%b valid=%b sel=%0d first=%b, expected all 0",
                  busy_o, valid_o, weight_select_o, first_o);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({valid_o, busy_o, done_o, row_rd_o} === 4'b0) n_pass++;
    else $display("FAIL idle_after_reset: got valid=%b busy=%b done=%b rd=%b, expected 0",
                  valid_o, busy_o, done_o, row_rd_o);
  endtask

  task automatic test_full_step;
    int unsigned cyc;
    int first_v;
    int done_c;
    conn_mode = 0;
    for (int i = 0; i < int'(NA); i++) begin
      @(negedge clk);
      type_wr_en_i = 1'b1; type_wr_addr_i = i[7:0]; type_wr_data_i = 2'd2;
      type_m[i] = 2'd2;
    end
    @(negedge clk);
    type_wr_en_i = 1'b0;
    start_i = 1'b1; spike_vec_i = '1; spike_m = '1; fetch_cnt = 0;
    @(negedge clk);
    start_i = 1'b0; spike_vec_i = '0;
    cyc = 1; first_v = -1; done_c = -1;
    n_checks++;
    if (row_rd_o === 1'b1 && busy_o === 1'b1) n_pass++;
    else $display("FAIL fetch_after_start: got rd=%b busy=%b expected 1 1", row_rd_o, busy_o);
    while (done_c < 0 && cyc <= STEP_CYC + 10) begin
      if (valid_o === 1'b1 && first_v < 0) first_v = int'(cyc);
      if (done_o === 1'b1) done_c = int'(cyc);
      // Write while scanning must be dropped; the model is left unchanged.
      if (cyc == 20) begin
        type_wr_en_i = 1'b1; type_wr_addr_i = 8'd7; type_wr_data_i = 2'd1;
      end
      if (cyc == 21) type_wr_en_i = 1'b0;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (first_v == 3) n_pass++;
    else $display("FAIL first_valid_latency: got %0d expected 3", first_v);
    n_checks++;
    if (done_c == int'(STEP_CYC)) n_pass++;
    else $display("FAIL done_latency: got %0d expected %0d", done_c, STEP_CYC);
    n_checks++;
    if (done_o === 1'b0 && busy_o === 1'b0) n_pass++;
    else $display("FAIL done_pulse_end: got done=%b busy=%b expected 0 0", done_o, busy_o);
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL beats_missing_full: got %0d left expected 0", sb.size());
    n_checks++;
    if (active_cnt_o === (CNT_EN ? 9'd256 : 9'd0)) n_pass++;
    else $display("FAIL active_cnt_full: got %0d expected %0d", active_cnt_o, CNT_EN ? 256 : 0);
  endtask

  task automatic test_stall_start_abort;
    logic [NA-1:0] pat;
    int unsigned cyc;
    bit stalled, pulsed, aborted, cnt_checked, bad_abort;
    conn_mode = 1;
    write_type(8'd7, 2'd1);
    pat = '0; pat[5] = 1'b1; pat[7] = 1'b1; pat[200] = 1'b1;
    @(negedge clk);
    start_i = 1'b1; spike_vec_i = pat; spike_m = pat; fetch_cnt = 0;
    // Same-cycle table write with start must take effect for this step.
    type_wr_en_i = 1'b1; type_wr_addr_i = 8'd5; type_wr_data_i = 2'd3; type_m[5] = 2'd3;
    @(negedge clk);
    start_i = 1'b0; spike_vec_i = '0; type_wr_en_i = 1'b0;
    cyc = 1; stalled = 0; pulsed = 0; aborted = 0; cnt_checked = 0;
    while (!aborted && cyc < 6 * (NA + 2)) begin
      if (!cnt_checked && row_rd_o === 1'b1 && neuron_idx_o === 8'd1) begin
        n_checks++;
        if (active_cnt_o === (CNT_EN ? 9'd1 : 9'd0)) n_pass++;
        else $display("FAIL active_cnt_n0: got %0d expected %0d", active_cnt_o, CNT_EN ? 1 : 0);
        cnt_checked = 1;
      end
      if (!stalled && valid_o === 1'b1 && neuron_idx_o === 8'd1 && axon_idx_o === 8'd100) begin
        ready_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          cyc++;
          n_checks++;
          if ({valid_o, neuron_idx_o, axon_idx_o, weight_select_o, first_o, last_o}
              === {1'b1, 8'd1, 8'd100, 8'd4, 1'b0, 1'b0}) n_pass++;
          else $display("FAIL stall_hold: got v=%b n%0d a%0d sel%0d expected v=1 n1 a100 sel4",
                        valid_o, neuron_idx_o, axon_idx_o, weight_select_o);
        end
        ready_i = 1'b1;
        stalled = 1;
      end
      if (!pulsed && valid_o === 1'b1 && neuron_idx_o === 8'd2 && axon_idx_o === 8'd10) begin
        start_i = 1'b1; spike_vec_i = '1;
        @(negedge clk);
        cyc++;
        start_i = 1'b0; spike_vec_i = '0;
        n_checks++;
        if ({busy_o, row_rd_o, neuron_idx_o, axon_idx_o} === {1'b1, 1'b0, 8'd2, 8'd11}) n_pass++;
        else $display("FAIL start_while_busy: got busy=%b rd=%b n%0d a%0d expected 1 0 n2 a11",
                      busy_o, row_rd_o, neuron_idx_o, axon_idx_o);
        pulsed = 1;
      end
      if (valid_o === 1'b1 && neuron_idx_o === 8'd3 && axon_idx_o === 8'd50) begin
        rst = 1'b1;
        #1;
        n_checks++;
        if ({row_rd_o, row_addr_o, valid_o, neuron_idx_o, axon_idx_o, weight_select_o,
             first_o, last_o, busy_o, done_o, active_cnt_o} === '0) n_pass++;
        else $display("FAIL abort_outputs: got busy=%b valid=%b n%0d a%0d expected all 0",
                      busy_o, valid_o, neuron_idx_o, axon_idx_o);
        bad_abort = 0;
        repeat (3) begin
          @(negedge clk);
          if (done_o !== 1'b0 || busy_o !== 1'b0) bad_abort = 1;
        end
        rst = 1'b0;
        @(negedge clk);
        if (done_o !== 1'b0 || busy_o !== 1'b0) bad_abort = 1;
        n_checks++;
        if (bad_abort == 0) n_pass++;
        else $display("FAIL abort_no_done: got done/busy activity=1 expected 0");
        sb.delete();
        spike_m = '0;
        for (int i = 0; i < int'(NA); i++) type_m[i] = 2'd0;
        aborted = 1;
      end
      if (!aborted) begin
        @(negedge clk);
        cyc++;
      end
    end
    n_checks++;
    if (stalled && pulsed && aborted && cnt_checked) n_pass++;
    else $display("FAIL scenario_reached: got stall=%0d pulse=%0d abort=%0d cnt=%0d expected 1 1 1 1",
                  stalled, pulsed, aborted, cnt_checked);
  endtask

  task automatic test_restart;
    logic [NA-1:0] pat;
    int unsigned cyc;
    conn_mode = 1;
    pat = '0; pat[5] = 1'b1; pat[7] = 1'b1;
    @(negedge clk);
    start_i = 1'b1; spike_vec_i = pat; spike_m = pat; fetch_cnt = 0;
    @(negedge clk);
    start_i = 1'b0; spike_vec_i = '0;
    cyc = 1;
    while (valid_o !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc == 3 && {neuron_idx_o, axon_idx_o, first_o} === {8'd0, 8'd0, 1'b1}) n_pass++;
    else $display("FAIL restart_first_beat: got cyc%0d n%0d a%0d f%b expected cyc3 n0 a0 f1",
                  cyc, neuron_idx_o, axon_idx_o, first_o);
    cyc = 0;
    while (!(row_rd_o === 1'b1 && neuron_idx_o === 8'd1) && cyc < 2 * (NA + 2)) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (row_rd_o === 1'b1 && sb.size() == 0) n_pass++;
    else $display("FAIL restart_row0_beats: got rd=%b left=%0d expected rd=1 left=0", row_rd_o, sb.size());
    n_checks++;
    if (active_cnt_o === (CNT_EN ? 9'd1 : 9'd0)) n_pass++;
    else $display("FAIL active_cnt_restart: got %0d expected %0d", active_cnt_o, CNT_EN ? 1 : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_step();
    test_stall_start_abort();
    test_restart();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
